// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: constants and helpers shared by the register scoreboard.
//   REG_ADDR_W  - register index width
//   NUM_REGS    - architectural register count (x0 included)
//   cnt_max_val - all-ones value of a pending-write counter of a given width
package reg_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic int unsigned cnt_max_val(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Saturating up/down counter; simultaneous inc and dec cancel.
//   i_clk   - clock, rising edge
//   i_rst   - synchronous active-low reset
//   i_inc   - one more write issued to this register
//   i_dec   - one write retired from this register
//   o_cnt   - current pending-write count
//   o_zero  - count is zero
//   o_max   - count is at its maximum
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max_val(CNT_W));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_cnt <= '0;
        end else if (i_inc && !i_dec && o_cnt != CNT_MAX) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && o_cnt != '0) begin
            o_cnt <= o_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (o_cnt == '0);
    assign o_max  = (o_cnt == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: read-side hazard tracker for the 32x32 register file.
// Holds issue while a used source register has an outstanding write, or the
// destination's pending counter is full. A writeback in the same cycle is
// treated as already visible (register file commits on the falling edge).
//   i_clk, i_rst            - clock / synchronous active-low reset
//   i_issue_*               - instruction presented by decode
//   o_issue_ready           - instruction may issue this cycle (combinational)
//   i_wb_valid, i_wb_rd_addr- one write retired this cycle
//   o_rs1_busy, o_rs2_busy  - source hazard flags (combinational)
//   o_stall_cycles          - saturating count of valid && !ready cycles
//   o_err                   - sticky: writeback to a register with nothing pending
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_issue_valid,
    input  logic [4:0]         i_issue_rs1_addr,
    input  logic [4:0]         i_issue_rs2_addr,
    input  logic               i_issue_rs1_used,
    input  logic               i_issue_rs2_used,
    input  logic [4:0]         i_issue_rd_addr,
    input  logic               i_issue_rd_wren,
    output logic               o_issue_ready,
    input  logic               i_wb_valid,
    input  logic [4:0]         i_wb_rd_addr,
    output logic               o_rs1_busy,
    output logic               o_rs2_busy,
    output logic [STALL_W-1:0] o_stall_cycles,
    output logic               o_err
);

    logic [CNT_W-1:0] cnt      [NUM_REGS];
    logic             cnt_zero [NUM_REGS];
    logic             cnt_max  [NUM_REGS];
    logic             full;
    logic             fire;

    // x0 never holds a pending write: constant zero slot keeps indexing uniform.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_x0
            assign cnt[r]      = '0;
            assign cnt_zero[r] = 1'b1;
            assign cnt_max[r]  = 1'b0;
        end else begin : g_cnt
            logic inc_en;
            logic dec_en;
            assign inc_en = fire && i_issue_rd_wren
                            && (i_issue_rd_addr == REG_ADDR_W'(r));
            assign dec_en = i_wb_valid && (i_wb_rd_addr == REG_ADDR_W'(r))
                            && !cnt_zero[r];
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_inc  (inc_en),
                .i_dec  (dec_en),
                .o_cnt  (cnt[r]),
                .o_zero (cnt_zero[r]),
                .o_max  (cnt_max[r])
            );
        end
    end

    // A source is clear if nothing is pending, or the only pending write
    // retires this very cycle.
    always_comb begin
        o_rs1_busy = i_issue_rs1_used && (i_issue_rs1_addr != '0)
                     && !cnt_zero[i_issue_rs1_addr]
                     && !(i_wb_valid && i_wb_rd_addr == i_issue_rs1_addr
                          && cnt[i_issue_rs1_addr] == CNT_W'(1));
        o_rs2_busy = i_issue_rs2_used && (i_issue_rs2_addr != '0)
                     && !cnt_zero[i_issue_rs2_addr]
                     && !(i_wb_valid && i_wb_rd_addr == i_issue_rs2_addr
                          && cnt[i_issue_rs2_addr] == CNT_W'(1));
        // A same-cycle writeback to rd frees a slot, so a full counter can
        // still accept the issue (inc and dec cancel).
        full = i_issue_rd_wren && (i_issue_rd_addr != '0)
               && cnt_max[i_issue_rd_addr]
               && !(i_wb_valid && i_wb_rd_addr == i_issue_rd_addr);
        o_issue_ready = !o_rs1_busy && !o_rs2_busy && !full;
        fire          = i_issue_valid && o_issue_ready;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_stall_cycles <= '0;
            o_err          <= 1'b0;
        end else begin
            if (i_issue_valid && !o_issue_ready && o_stall_cycles != '1) begin
                o_stall_cycles <= o_stall_cycles + STALL_W'(1);
            end
            if (i_wb_valid && i_wb_rd_addr != '0 && cnt_zero[i_wb_rd_addr]) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int CNT_W   = 2;
    localparam int STALL_W = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid;
    logic [4:0]         rs1_addr, rs2_addr, rd_addr, wb_addr;
    logic               rs1_used, rs2_used, rd_wren, wb_valid;
    logic               issue_ready, rs1_busy, rs2_busy, err;
    logic [STALL_W-1:0] stall_cycles;

    int                 model_cnt [32];
    int                 model_stall;
    logic               model_err;
    int                 n_checks = 0;
    int                 n_errors = 0;

    logic               last_ready, last_b1, last_b2, last_err;
    int                 last_stall;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_issue_valid    (issue_valid),
        .i_issue_rs1_addr (rs1_addr),
        .i_issue_rs2_addr (rs2_addr),
        .i_issue_rs1_used (rs1_used),
        .i_issue_rs2_used (rs2_used),
        .i_issue_rd_addr  (rd_addr),
        .i_issue_rd_wren  (rd_wren),
        .o_issue_ready    (issue_ready),
        .i_wb_valid       (wb_valid),
        .i_wb_rd_addr     (wb_addr),
        .o_rs1_busy       (rs1_busy),
        .o_rs2_busy       (rs2_busy),
        .o_stall_cycles   (stall_cycles),
        .o_err            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writes still outstanding once this cycle's writeback (if any) is counted.
    function automatic int remaining(input logic [4:0] r, input logic wbv, input logic [4:0] wba);
        return model_cnt[r] - ((wbv && wba == r) ? 1 : 0);
    endfunction

    task automatic step(input logic r_n, input logic v,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] rd, input logic w,
                        input logic wbv, input logic [4:0] wba);
        logic eb1, eb2, efull, erdy;
        @(negedge clk);
        rst = r_n; issue_valid = v;
        rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
        rd_addr = rd; rd_wren = w; wb_valid = wbv; wb_addr = wba;
        #1;
        eb1   = u1 && a1 != 0 && remaining(a1, wbv, wba) > 0;
        eb2   = u2 && a2 != 0 && remaining(a2, wbv, wba) > 0;
        efull = w && rd != 0 && remaining(rd, wbv, wba) >= MAXC;
        erdy  = !eb1 && !eb2 && !efull;
        check("rs1_busy", 32'(rs1_busy), 32'(eb1));
        check("rs2_busy", 32'(rs2_busy), 32'(eb2));
        check("ready", 32'(issue_ready), 32'(erdy));
        check("stall_cycles", 32'(stall_cycles), 32'(model_stall));
        check("err", 32'(err), 32'(model_err));
        last_ready = issue_ready; last_b1 = rs1_busy; last_b2 = rs2_busy;
        last_err = err; last_stall = int'(stall_cycles);
        @(posedge clk);
        if (!r_n) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
            model_stall = 0;
            model_err   = 1'b0;
        end else begin
            if (wbv && wba != 0) begin
                if (model_cnt[wba] == 0) model_err = 1'b1;
                else model_cnt[wba]--;
            end
            if (v && erdy && w && rd != 0) model_cnt[rd]++;
            if (v && !erdy && model_stall < (1 << STALL_W) - 1) model_stall++;
        end
    endtask

    task automatic idle(input logic r_n);
        step(r_n, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [4:0] pool [5];

    initial begin
        pool[0] = 5'd0; pool[1] = 5'd5; pool[2] = 5'd7; pool[3] = 5'd9; pool[4] = 5'd31;
        rst = 1'b0; issue_valid = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        rs1_used = 0; rs2_used = 0; rd_wren = 0; wb_valid = 0; wb_addr = 0;
        repeat (2) @(posedge clk);
        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_stall = 0; model_err = 1'b0;

        // Reset state
        idle(1);
        check("rst_ready", 32'(last_ready), 1);
        check("rst_busy", 32'({last_b1, last_b2}), 0);
        check("rst_stall", 32'(last_stall), 0);

        // Issue rd=5, then dependent issue stalls
        step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        check("tp1_issue_ready", 32'(last_ready), 1);
        repeat (3) step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        check("tp1_dep_ready", 32'(last_ready), 0);
        check("tp1_dep_busy", 32'(last_b1), 1);
        // Same-cycle writeback bypass
        step(1, 1, 5, 1, 0, 0, 0, 0, 1, 5);
        check("tp1_stall3", 32'(last_stall), 3);
        check("tp2_bypass_ready", 32'(last_ready), 1);
        step(1, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        check("tp2_cleared", 32'(last_b1), 0);

        // Fill x7 to max, then full / full-with-writeback
        repeat (3) step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        check("tp3_full_ready", 32'(last_ready), 0);
        step(1, 1, 0, 0, 0, 0, 7, 1, 1, 7);
        check("tp3_full_wb_ready", 32'(last_ready), 1);
        step(1, 1, 7, 1, 0, 0, 0, 0, 1, 7);
        check("tp3_still_busy", 32'(last_b1), 1);

        // x0 never busy, wb to x0 ignored
        step(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        check("tp4_x0_ready", 32'(last_ready), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        check("tp4_no_err", 32'(last_err), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7);

        // Unused rs2 on a busy register
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        step(1, 1, 0, 0, 9, 0, 0, 0, 0, 0);
        check("tp6_rs2_unused_busy", 32'(last_b2), 0);
        check("tp6_rs2_unused_ready", 32'(last_ready), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);

        // Spurious writeback sets sticky error; reset clears it
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        idle(1);
        check("tp5_err_set", 32'(last_err), 1);
        idle(1);
        check("tp5_err_sticky", 32'(last_err), 1);
        step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("tp5_rst_err", 32'(last_err), 0);
        check("tp5_rst_stall", 32'(last_stall), 0);
        step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        check("tp5_rst_cnt", 32'(last_b1), 0);

        // Stall counter saturation
        step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        repeat (20) step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("stall_sat", 32'(last_stall), (1 << STALL_W) - 1);
        idle(0);

        // Randomized traffic over a small register pool
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) != 0),
                 ($urandom_range(3) != 0),
                 pool[$urandom_range(4)], 1'($urandom),
                 pool[$urandom_range(4)], 1'($urandom),
                 pool[$urandom_range(4)], ($urandom_range(3) != 0),
                 ($urandom_range(2) == 0), pool[$urandom_range(4)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
